// File: rtl/tx_fifo_pkg.sv
// Shared types and format helpers for the TX FIFO unpacker.
package tx_fifo_pkg;

  localparam int DATA_W_C = 128;
  localparam int LANE_W_C = 64;

  typedef enum logic [2:0] {
    FMT_64C = 3'd0,
    FMT_64R = 3'd1,
    FMT_32C = 3'd2,
    FMT_32R = 3'd3,
    FMT_16C = 3'd4,
    FMT_16R = 3'd5,
    FMT_8C  = 3'd6,
    FMT_8R  = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  function automatic logic [4:0] samples_per_word(fmt_e f);
    case (f)
      FMT_64C:          return 5'd1;
      FMT_64R, FMT_32C: return 5'd2;
      FMT_32R, FMT_16C: return 5'd4;
      FMT_16R, FMT_8C:  return 5'd8;
      default:          return 5'd16;
    endcase
  endfunction

  function automatic logic [6:0] sample_width(fmt_e f);
    case (f)
      FMT_64C, FMT_64R: return 7'd64;
      FMT_32C, FMT_32R: return 7'd32;
      FMT_16C, FMT_16R: return 7'd16;
      default:          return 7'd8;
    endcase
  endfunction

  // Even encodings are the complex (I/Q) formats.
  function automatic logic is_complex(fmt_e f);
    return (f[0] == 1'b0);
  endfunction

endpackage

// File: rtl/tx_sample_slicer.sv
// Combinational pick of sample idx from a 128-bit word into the I/Q lane layout.
// TX_SIGN_EXT_EN: sign-extend narrow samples within their lane; otherwise zero-fill.
module tx_sample_slicer
  import tx_fifo_pkg::*;
(
  input  logic [127:0] word,
  input  logic [3:0]   idx,
  input  logic [2:0]   fmt,
  output logic [127:0] sample
);

  fmt_e        f;
  logic [6:0]  width;
  logic [7:0]  base;
  logic [63:0] mask;
  logic [63:0] lane_i;
  logic [63:0] lane_q;

  always_comb begin
    f     = fmt_e'(fmt);
    width = sample_width(f);
    mask  = (width == 7'd64) ? '1 : ((64'd1 << width) - 64'd1);
    if (is_complex(f)) begin
      base = {3'b000, idx, 1'b0} * {1'b0, width};
    end else begin
      base = {4'b0000, idx} * {1'b0, width};
    end
    lane_i = 64'(word >> base) & mask;
    lane_q = is_complex(f) ? (64'(word >> (base + {1'b0, width})) & mask) : '0;
`ifdef TX_SIGN_EXT_EN
    if (|(lane_i & ~(mask >> 1))) lane_i = lane_i | ~mask;
    if (|(lane_q & ~(mask >> 1))) lane_q = lane_q | ~mask;
`endif
    sample = {lane_q, lane_i};
  end

endmodule

// File: rtl/tx_fifo_axis.sv
// AXIS -> dual-clock FIFO -> per-sample unpacker on the DAC clock, one sample per data_req.
// Optional TX_SIGN_EXT_EN selects sign extension of narrow samples (see tx_sample_slicer).
module tx_fifo_axis
  import tx_fifo_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int LANE_W = 64
) (
  input  logic                fifo_rd_clk,
  input  logic                aresetn,
  input  logic                tx_enable,
  input  logic [2:0]          data_format,
  input  logic                data_req,
  output logic [2*LANE_W-1:0] data_out,
  output logic                data_valid,
  output logic                underflow,
  input  logic [DATA_W-1:0]   s_axis_tx_tdata,
  input  logic                s_axis_tx_tvalid,
  output logic                s_axis_tx_tready,
  output logic                fifo_srst,
  output logic [DATA_W-1:0]   fifo_wr_data,
  output logic                fifo_wr_en,
  input  logic                fifo_wr_full,
  input  logic                fifo_wr_rst_busy,
  input  logic [DATA_W-1:0]   fifo_rd_data,
  output logic                fifo_rd_en,
  input  logic                fifo_rd_empty,
  input  logic                fifo_rd_valid,
  input  logic                fifo_rd_rst_busy
);

  logic         en_meta;
  logic         tx_en_s;
  state_e       state;
  fmt_e         fmt_q;
  logic [3:0]   idx;
  logic [127:0] cur;
  logic [127:0] nxt;
  logic         cur_vld;
  logic         nxt_vld;
  logic [127:0] slice;
  logic         consume;
  logic         last;
  logic         nxt_vld_n;
  logic         rd_issue;

  always_ff @(posedge fifo_rd_clk or negedge aresetn) begin
    if (!aresetn) begin
      en_meta <= 1'b0;
      tx_en_s <= 1'b0;
    end else begin
      en_meta <= tx_enable;
      tx_en_s <= en_meta;
    end
  end

  assign fifo_srst        = ~(aresetn & tx_en_s);
  assign s_axis_tx_tready = ~fifo_wr_full & ~fifo_wr_rst_busy & ~fifo_srst;
  assign fifo_wr_en       = s_axis_tx_tvalid & s_axis_tx_tready;
  assign fifo_wr_data     = s_axis_tx_tdata;

  tx_sample_slicer u_slicer (
    .word   (cur),
    .idx    (idx),
    .fmt    (fmt_q),
    .sample (slice)
  );

  // At most one read is in flight and it is only issued when nxt will be free on arrival,
  // so an arriving word always has a slot (cur if empty, else nxt).
  always_comb begin
    consume = (state == RUN) & data_req & cur_vld;
    last    = ({1'b0, idx} == (samples_per_word(fmt_q) - 5'd1));
    if (consume & last) begin
      nxt_vld_n = nxt_vld & fifo_rd_valid;
    end else begin
      nxt_vld_n = nxt_vld | (fifo_rd_valid & cur_vld);
    end
    rd_issue = (state != IDLE) & tx_en_s & ~fifo_rd_en & ~nxt_vld_n &
               ~fifo_rd_empty & ~fifo_rd_rst_busy;
  end

  always_ff @(posedge fifo_rd_clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      fmt_q      <= FMT_64C;
      idx        <= '0;
      cur        <= '0;
      nxt        <= '0;
      cur_vld    <= 1'b0;
      nxt_vld    <= 1'b0;
      fifo_rd_en <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      underflow  <= 1'b0;
    end else if (!tx_en_s) begin
      state      <= IDLE;
      idx        <= '0;
      cur        <= '0;
      nxt        <= '0;
      cur_vld    <= 1'b0;
      nxt_vld    <= 1'b0;
      fifo_rd_en <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      fifo_rd_en <= rd_issue;
      case (state)
        IDLE: begin
          data_valid <= 1'b0;
          data_out   <= '0;
          if (!fifo_rd_rst_busy) begin
            state     <= FILL;
            fmt_q     <= fmt_e'(data_format);
            underflow <= 1'b0;
          end
        end
        FILL: begin
          data_valid <= 1'b0;
          if (data_req) data_out <= '0;
          if (cur_vld) state <= RUN;
        end
        RUN: begin
          if (data_req) begin
            if (cur_vld) begin
              data_out   <= slice;
              data_valid <= 1'b1;
            end else begin
              data_out   <= '0;
              data_valid <= 1'b0;
              underflow  <= 1'b1;
            end
          end else begin
            data_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (state != IDLE) begin
        if (consume & last) begin
          idx <= '0;
          if (nxt_vld) begin
            cur     <= nxt;
            cur_vld <= 1'b1;
            nxt     <= fifo_rd_data;
            nxt_vld <= fifo_rd_valid;
          end else begin
            cur     <= fifo_rd_data;
            cur_vld <= fifo_rd_valid;
          end
        end else begin
          if (consume) idx <= idx + 4'd1;
          if (fifo_rd_valid) begin
            if (!cur_vld) begin
              cur     <= fifo_rd_data;
              cur_vld <= 1'b1;
            end else begin
              nxt     <= fifo_rd_data;
              nxt_vld <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_fifo_axis.sv
// Bench for tx_fifo_axis: queue-based FIFO model, directed corner cases and a randomized scoreboard.
`timescale 1ns/1ps
module tb_tx_fifo_axis;

  logic         fifo_rd_clk = 1'b0;
  logic         aresetn;
  logic         tx_enable;
  logic [2:0]   data_format;
  logic         data_req;
  logic [127:0] data_out;
  logic         data_valid;
  logic         underflow;
  logic [127:0] s_axis_tx_tdata;
  logic         s_axis_tx_tvalid;
  logic         s_axis_tx_tready;
  logic         fifo_srst;
  logic [127:0] fifo_wr_data;
  logic         fifo_wr_en;
  logic         fifo_wr_full;
  logic         fifo_wr_rst_busy;
  logic [127:0] fifo_rd_data;
  logic         fifo_rd_en;
  logic         fifo_rd_empty;
  logic         fifo_rd_valid;
  logic         fifo_rd_rst_busy;

  always #5 fifo_rd_clk = ~fifo_rd_clk;

  tx_fifo_axis dut (
    .fifo_rd_clk      (fifo_rd_clk),
    .aresetn          (aresetn),
    .tx_enable        (tx_enable),
    .data_format      (data_format),
    .data_req         (data_req),
    .data_out         (data_out),
    .data_valid       (data_valid),
    .underflow        (underflow),
    .s_axis_tx_tdata  (s_axis_tx_tdata),
    .s_axis_tx_tvalid (s_axis_tx_tvalid),
    .s_axis_tx_tready (s_axis_tx_tready),
    .fifo_srst        (fifo_srst),
    .fifo_wr_data     (fifo_wr_data),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_wr_full     (fifo_wr_full),
    .fifo_wr_rst_busy (fifo_wr_rst_busy),
    .fifo_rd_data     (fifo_rd_data),
    .fifo_rd_en       (fifo_rd_en),
    .fifo_rd_empty    (fifo_rd_empty),
    .fifo_rd_valid    (fifo_rd_valid),
    .fifo_rd_rst_busy (fifo_rd_rst_busy)
  );

  // Standard (non-FWFT) FIFO model: read data appears the cycle after rd_en.
  localparam int DEPTH = 16;
  logic [127:0] fq[$];
  logic         model_full;
  logic         force_full;
  assign fifo_wr_full = model_full | force_full;

  always @(posedge fifo_rd_clk or negedge aresetn) begin
    if (!aresetn) begin
      fq.delete();
      fifo_rd_valid <= 1'b0;
      fifo_rd_data  <= '0;
      fifo_rd_empty <= 1'b1;
      model_full    <= 1'b0;
    end else if (fifo_srst) begin
      fq.delete();
      fifo_rd_valid <= 1'b0;
      fifo_rd_empty <= 1'b1;
      model_full    <= 1'b0;
    end else begin
      if (fifo_rd_en && fq.size() > 0) begin
        fifo_rd_data  <= fq.pop_front();
        fifo_rd_valid <= 1'b1;
      end else begin
        fifo_rd_valid <= 1'b0;
      end
      if (fifo_wr_en) fq.push_back(fifo_wr_data);
      fifo_rd_empty <= (fq.size() == 0);
      model_full    <= (fq.size() >= DEPTH);
    end
  end

  // Reference: split the word into W-bit fields; complex k -> fields 2k/2k+1, real k -> field k.
  function automatic int model_w(input int fmt);
    return (fmt < 2) ? 64 : (fmt < 4) ? 32 : (fmt < 6) ? 16 : 8;
  endfunction

  function automatic int model_n(input int fmt);
    return 128 / (model_w(fmt) * (((fmt % 2) == 0) ? 2 : 1));
  endfunction

  function automatic logic [127:0] model_sample(input logic [127:0] w, input int fmt, input int k);
    int wd;
    logic [63:0] fld[16];
    logic [63:0] iv;
    logic [63:0] qv;
    wd = model_w(fmt);
    for (int j = 0; j < 16; j++) fld[j] = '0;
    for (int j = 0; j < 128 / wd; j++)
      for (int b = 0; b < wd; b++) fld[j][b] = w[j*wd + b];
    if ((fmt % 2) == 0) begin
      iv = fld[2*k];
      qv = fld[2*k + 1];
    end else begin
      iv = fld[k];
      qv = '0;
    end
`ifdef TX_SIGN_EXT_EN
    if (iv[wd-1]) for (int b = wd; b < 64; b++) iv[b] = 1'b1;
    if (qv[wd-1]) for (int b = wd; b < 64; b++) qv[b] = 1'b1;
`endif
    return {qv, iv};
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge fifo_rd_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic enable(input int fmt);
    int t;
    t = 0;
    data_format = 3'(fmt);
    tx_enable   = 1'b1;
    while (fifo_srst && t < 20) begin
      step();
      t++;
    end
    check1("enable_srst_release", fifo_srst, 1'b0);
    steps(2);
  endtask

  task automatic disable_tx();
    tx_enable = 1'b0;
    data_req  = 1'b0;
    steps(5);
  endtask

  task automatic push(input logic [127:0] w);
    int t;
    t = 0;
    s_axis_tx_tdata  = w;
    s_axis_tx_tvalid = 1'b1;
    while (!s_axis_tx_tready && t < 50) begin
      step();
      t++;
    end
    check1("push_ready", s_axis_tx_tready, 1'b1);
    step();
    s_axis_tx_tvalid = 1'b0;
  endtask

  typedef struct {
    logic full;
    logic wbusy;
    logic tvalid;
    logic exp_ready;
    logic exp_wen;
  } hs_vec_t;

  typedef struct {
    logic [127:0] exp;
  } f4_vec_t;

  hs_vec_t      hs_tab[6];
  f4_vec_t      f4_tab[4];
  logic [127:0] expq[$];
  logic [127:0] wa, wb, w1, w2, w3, w7, rw;
  logic [127:0] fw[4];
  logic [63:0]  exp7;
  logic         r;
  int           fmt, nw, issued, total, cyc;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    hs_tab[0] = '{full:1'b0, wbusy:1'b0, tvalid:1'b1, exp_ready:1'b1, exp_wen:1'b1};
    hs_tab[1] = '{full:1'b0, wbusy:1'b0, tvalid:1'b0, exp_ready:1'b1, exp_wen:1'b0};
    hs_tab[2] = '{full:1'b1, wbusy:1'b0, tvalid:1'b1, exp_ready:1'b0, exp_wen:1'b0};
    hs_tab[3] = '{full:1'b0, wbusy:1'b1, tvalid:1'b1, exp_ready:1'b0, exp_wen:1'b0};
    hs_tab[4] = '{full:1'b1, wbusy:1'b1, tvalid:1'b1, exp_ready:1'b0, exp_wen:1'b0};
    hs_tab[5] = '{full:1'b1, wbusy:1'b0, tvalid:1'b0, exp_ready:1'b0, exp_wen:1'b0};
    f4_tab[0].exp = 128'h0000_0000_0000_0222_0000_0000_0000_0111;
    f4_tab[1].exp = 128'h0000_0000_0000_0444_0000_0000_0000_0333;
    f4_tab[2].exp = 128'h0000_0000_0000_0002_0000_0000_0000_0001;
    f4_tab[3].exp = 128'h0000_0000_0000_0004_0000_0000_0000_0003;

    aresetn          = 1'b0;
    tx_enable        = 1'b0;
    data_format      = 3'd0;
    data_req         = 1'b0;
    s_axis_tx_tdata  = '0;
    s_axis_tx_tvalid = 1'b0;
    fifo_wr_rst_busy = 1'b0;
    fifo_rd_rst_busy = 1'b0;
    force_full       = 1'b0;
    steps(3);
    check1("rst_data_valid", data_valid, 1'b0);
    check("rst_data_out", data_out, '0);
    check1("rst_underflow", underflow, 1'b0);
    check1("rst_rd_en", fifo_rd_en, 1'b0);
    check1("rst_srst", fifo_srst, 1'b1);
    check1("rst_tready", s_axis_tx_tready, 1'b0);
    aresetn = 1'b1;
    steps(2);
    check1("disabled_srst", fifo_srst, 1'b1);

    // Write-side handshake table, applied without letting an edge pass.
    enable(0);
    for (int i = 0; i < 6; i++) begin
      force_full       = hs_tab[i].full;
      fifo_wr_rst_busy = hs_tab[i].wbusy;
      s_axis_tx_tvalid = hs_tab[i].tvalid;
      #1;
      check1($sformatf("hs%0d_tready", i), s_axis_tx_tready, hs_tab[i].exp_ready);
      check1($sformatf("hs%0d_wr_en", i), fifo_wr_en, hs_tab[i].exp_wen);
      s_axis_tx_tvalid = 1'b0;
      force_full       = 1'b0;
      fifo_wr_rst_busy = 1'b0;
      #1;
    end

    // fmt0: two words, back-to-back requests, latency 1.
    wa = {$urandom, $urandom, $urandom, $urandom};
    wb = {$urandom, $urandom, $urandom, $urandom};
    push(wa);
    push(wb);
    steps(8);
    check1("fmt0_pre_valid", data_valid, 1'b0);
    data_req = 1'b1;
    step();
    check1("fmt0_a_valid", data_valid, 1'b1);
    check("fmt0_a", data_out, wa);
    step();
    check1("fmt0_b_valid", data_valid, 1'b1);
    check("fmt0_b", data_out, wb);
    data_req = 1'b0;
    step();
    check1("fmt0_idle_valid", data_valid, 1'b0);
    check("fmt0_hold", data_out, wb);
    check1("fmt0_underflow", underflow, 1'b0);
    disable_tx();

    // fmt4: I/Q pairs lowest first against hand-computed lanes.
    enable(4);
    push(128'h0004_0003_0002_0001_0444_0333_0222_0111);
    steps(8);
    data_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check1($sformatf("fmt4_valid%0d", k), data_valid, 1'b1);
      check($sformatf("fmt4_s%0d", k), data_out, f4_tab[k].exp);
    end
    data_req = 1'b0;
    disable_tx();

    // fmt7: negative byte, extension depends on the build option.
    w7 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6680;
`ifdef TX_SIGN_EXT_EN
    exp7 = 64'hFFFF_FFFF_FFFF_FF80;
`else
    exp7 = 64'h0000_0000_0000_0080;
`endif
    enable(7);
    push(w7);
    steps(8);
    data_req = 1'b1;
    step();
    data_req = 1'b0;
    check1("fmt7_valid", data_valid, 1'b1);
    check("fmt7_lane_i", {64'd0, data_out[63:0]}, {64'd0, exp7});
    check("fmt7_lane_q", {64'd0, data_out[127:64]}, '0);
    disable_tx();

    // fmt5: four preloaded words, 32 requests back to back.
    enable(5);
    for (int i = 0; i < 4; i++) begin
      fw[i] = {$urandom, $urandom, $urandom, $urandom};
      push(fw[i]);
    end
    steps(10);
    data_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      check1($sformatf("fmt5_valid%0d", i), data_valid, 1'b1);
      check($sformatf("fmt5_s%0d", i), data_out, model_sample(fw[i/8], 5, i % 8));
    end
    data_req = 1'b0;
    step();
    check1("fmt5_underflow", underflow, 1'b0);
    disable_tx();

    // fmt3: one word only, fifth request underflows and the flag sticks.
    enable(3);
    w1 = {$urandom, $urandom, $urandom, $urandom};
    push(w1);
    steps(8);
    data_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("fmt3_s%0d", k), data_out, model_sample(w1, 3, k));
    end
    step();
    check1("fmt3_uf_valid", data_valid, 1'b0);
    check("fmt3_uf_data", data_out, '0);
    check1("fmt3_uf_flag", underflow, 1'b1);
    data_req = 1'b0;
    steps(3);
    check1("fmt3_uf_sticky", underflow, 1'b1);

    // Drop tx_enable at idx=2, then re-enable on a fresh word.
    w1 = {$urandom, $urandom, $urandom, $urandom};
    w2 = {$urandom, $urandom, $urandom, $urandom};
    push(w1);
    push(w2);
    steps(8);
    data_req = 1'b1;
    step();
    check("drop_s0", data_out, model_sample(w1, 3, 0));
    step();
    check("drop_s1", data_out, model_sample(w1, 3, 1));
    data_req  = 1'b0;
    tx_enable = 1'b0;
    steps(4);
    check1("drop_srst", fifo_srst, 1'b1);
    check1("drop_valid", data_valid, 1'b0);
    check1("drop_uf_held", underflow, 1'b1);
    enable(3);
    check1("reen_uf_clear", underflow, 1'b0);
    w3 = {$urandom, $urandom, $urandom, $urandom};
    push(w3);
    steps(8);
    data_req = 1'b1;
    step();
    data_req = 1'b0;
    check1("reen_valid", data_valid, 1'b1);
    check("reen_s0", data_out, model_sample(w3, 3, 0));
    disable_tx();

    // Randomized: random format, preloaded words, random request gaps.
    for (int it = 0; it < 8; it++) begin
      fmt = $urandom_range(1, 7);
      expq.delete();
      enable(fmt);
      nw = $urandom_range(2, 6);
      for (int w = 0; w < nw; w++) begin
        rw = {$urandom, $urandom, $urandom, $urandom};
        push(rw);
        for (int k = 0; k < model_n(fmt); k++) expq.push_back(model_sample(rw, fmt, k));
      end
      steps(12);
      total  = expq.size();
      issued = 0;
      cyc    = 0;
      while (issued < total && cyc < 1000) begin
        r = ($urandom_range(0, 3) != 0);
        data_req = r;
        if (r) issued++;
        step();
        cyc++;
        check1("rnd_valid", data_valid, r);
        if (data_valid && expq.size() > 0) check("rnd_data", data_out, expq.pop_front());
      end
      data_req = 1'b0;
      step();
      check("rnd_drain", 128'(expq.size()), '0);
      check1("rnd_underflow", underflow, 1'b0);
      disable_tx();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
